booth_mult_ctrl: RTL and testbench
==================================

BOOTH_MULT_CTRL -- requirements
Module: booth_mult_ctrl

Interface
REQ-001 SHALL use one clock and one reset: the clock is clk and the reset is rst_n; reset is asynchronous and active-low.
REQ-002 SHALL have ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, request a multiply; accepted only in IDLE.
- is_signed, input, 1, 1 = MULT (two's complement), 0 = MULTU.
- abort, input, 1, cancel the in-flight operation (pipeline flush or exception).
- mcand, input, 32, multiplicand; sampled on accept.
- mplier, input, 32, multiplier; sampled on accept.
- busy, output, 1, high in RUN.
- done, output, 1, one-cycle pulse when the result is ready.
- hi, output, 32, upper product word.
- lo, output, 32, lower product word.

Function
REQ-003 SHALL implement FSM states IDLE, RUN and DONE.
- IDLE->RUN on start.
- RUN->DONE when the step counter reaches its last step.
- DONE->IDLE unconditionally after one cycle.
REQ-004 SHALL, on accept, latch both operands and is_signed, clear the accumulator and the step counter, and set the implicit Booth bit y[-1] = 0.
REQ-005 SHALL extend operands to 34 bits before recoding: sign-extended when is_signed=1, zero-extended when is_signed=0.
REQ-006 SHALL, each RUN cycle, recode the 3-bit window {y[2i+1], y[2i], y[2i-1]} into a digit d in {-2,-1,0,+1,+2}.
- 000 and 111 give 0.
- 001 and 010 give +1.
- 011 gives +2.
- 100 gives -2.
- 101 and 110 give -1.
REQ-007 SHALL add d×mcand_ext at weight 4^i into a 66-bit accumulator, then shift the multiplier window by 2 bits.
REQ-008 SHALL take 16 RUN cycles for signed operations and 17 for unsigned ones.
- Latency from start accept to the done pulse is 17 cycles (signed) or 18 (unsigned).
REQ-009 SHALL produce {hi,lo} equal to the exact 64-bit product of the latched operands, with no overflow or saturation.
REQ-010 SHALL update hi/lo only on the cycle done is asserted, and hold them until the next completed operation.
REQ-011 SHALL ignore start while in RUN or DONE, with no queuing; operand changes during RUN have no effect.
REQ-012 SHALL treat abort in RUN as a return to IDLE on the next edge, with no done pulse and hi/lo unchanged.
- abort in IDLE or DONE has no effect.
- abort together with start in IDLE: abort wins and the request is not accepted.
REQ-013 SHALL accept a start asserted in the cycle after DONE (back-to-back operations).

Reset
REQ-014 SHALL, while rst_n=0, force state=IDLE, busy=0, done=0, hi=0, lo=0, and clear the accumulator and the counter.
REQ-015 SHALL, on reset asserted mid-RUN, discard the operation with no done pulse after release.

Configuration
REQ-016 SHALL support macro BOOTH_EARLY_TERM_EN.
- Defined: RUN ends early when all remaining unprocessed multiplier window bits equal the extended sign bit (every remaining digit is 0). The accumulator is then sign-corrected and DONE follows on the next cycle, so the minimum latency is 2 cycles (e.g. mplier=0).
- Undefined: the fixed latency of REQ-008 always applies.
- Results SHALL be identical in both builds.

Structure
REQ-017 SHALL place the FSM state encoding, the step counts (16/17) and the digit encoding (NOP/ADD/SUB × 1/2) in shared package booth_pkg.
REQ-018 SHALL isolate the recoding of REQ-006 in combinational sub-module booth_recoder (3-bit window in, digit magnitude and sign out), instantiated once.

Verification
REQ-019 SHALL pass these directed scenarios:
- Signed 7 × -3 -> {hi,lo}=0xFFFFFFFF_FFFFFFEB; done 17 cycles after accept.
- Unsigned 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE_00000001; done after 18 cycles.
- Signed 0x80000000 × 0x80000000 -> 0x40000000_00000000.
- abort at RUN cycle 5 -> no done, hi/lo retain the prior result; a new start the next cycle completes correctly.
- start pulsed during RUN -> ignored, single done; back-to-back start in the cycle after DONE -> second result correct.
- With BOOTH_EARLY_TERM_EN: signed 5 × 1 -> 0x00000000_00000005, done within 3 cycles; rst_n low mid-RUN -> all outputs 0, no done.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared definitions for the radix-4 Booth multiplier controller:
// FSM state encoding, step counts and the Booth digit encoding.
package booth_pkg;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Number of radix-4 digits processed per operation.
    // Signed operands need 16 digits; the zero-extended unsigned operand
    // needs one extra digit to pick up its top bit.
    localparam logic [4:0] STEPS_SIGNED   = 5'd16;
    localparam logic [4:0] STEPS_UNSIGNED = 5'd17;

    // Magnitude part of a Booth digit: no-op, 1x or 2x multiplicand
    typedef enum logic [1:0] {
        MAG_NOP = 2'd0,
        MAG_ONE = 2'd1,
        MAG_TWO = 2'd2
    } digit_mag_e;

    // Sign part of a Booth digit: add or subtract the selected multiple
    typedef enum logic {
        DIG_ADD = 1'b0,
        DIG_SUB = 1'b1
    } digit_sign_e;

    // Extend a 32-bit operand to 34 bits, sign- or zero-extended
    function automatic logic [33:0] extend_operand(input logic [31:0] value,
                                                   input logic        is_sgn);
        return {{2{is_sgn & value[31]}}, value};
    endfunction

endpackage

// File: rtl/booth_recoder.sv
// Radix-4 Booth recoder: maps a 3-bit multiplier window
// {y[2i+1], y[2i], y[2i-1]} onto a digit in {-2,-1,0,+1,+2},
// returned as a magnitude and a sign.
module booth_recoder
    import booth_pkg::*;
(
    input  logic [2:0]  window,
    output digit_mag_e  mag,
    output digit_sign_e sign
);

    // Pure table lookup; 000 and 111 fall through to the zero digit
    always_comb begin
        mag  = MAG_NOP;
        sign = DIG_ADD;
        case (window)
            3'b001, 3'b010: begin
                mag  = MAG_ONE;
                sign = DIG_ADD;
            end
            3'b011: begin
                mag  = MAG_TWO;
                sign = DIG_ADD;
            end
            3'b100: begin
                mag  = MAG_TWO;
                sign = DIG_SUB;
            end
            3'b101, 3'b110: begin
                mag  = MAG_ONE;
                sign = DIG_SUB;
            end
            default: begin
                mag  = MAG_NOP;
                sign = DIG_ADD;
            end
        endcase
    end

endmodule

// File: rtl/booth_mult_ctrl.sv
// Iterative radix-4 Booth multiplier (MULT / MULTU), one digit per cycle.
// Optional build macro BOOTH_EARLY_TERM_EN: finish RUN as soon as every
// remaining multiplier digit is zero.
module booth_mult_ctrl
    import booth_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_signed,
    input  logic        abort,
    input  logic [31:0] mcand,
    input  logic [31:0] mplier,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    state_e      state, state_nxt;
    logic [33:0] mcand_q;
    logic [34:0] mreg;
    logic [34:0] mreg_nxt;
    logic [65:0] acc;
    logic [65:0] acc_nxt;
    logic [65:0] partial;
    logic [4:0]  step;
    logic [4:0]  last_idx;
    logic        signed_q;
    logic        last_step;
    logic        accept;
    digit_mag_e  dig_mag;
    digit_sign_e dig_sign;

    // The low three bits of the multiplier shift register form the current window
    booth_recoder u_recoder (
        .window (mreg[2:0]),
        .mag    (dig_mag),
        .sign   (dig_sign)
    );

    assign accept   = (state == ST_IDLE) && start && !abort;
    assign last_idx = signed_q ? (STEPS_SIGNED - 5'd1) : (STEPS_UNSIGNED - 5'd1);

    // Build d*mcand at weight 4^step, accumulate it, and shift the window down two bits
    always_comb begin
        logic [65:0] mcand_wide;
        logic [65:0] multiple;
        mcand_wide = {{32{mcand_q[33]}}, mcand_q};
        multiple   = '0;
        case (dig_mag)
            MAG_ONE: multiple = mcand_wide;
            MAG_TWO: multiple = mcand_wide << 1;
            default: multiple = '0;
        endcase
        if (dig_sign == DIG_SUB) begin
            multiple = ~multiple + 66'd1;
        end
        partial  = multiple << {step, 1'b0};
        acc_nxt  = acc + partial;
        mreg_nxt = {mreg[34], mreg[34], mreg[34:2]};
`ifdef BOOTH_EARLY_TERM_EN
        // Once the remaining bits all match the sign, every later digit is zero
        // and the accumulator already holds the exact product.
        last_step = (step == last_idx) || (mreg_nxt == '0) || (mreg_nxt == '1);
`else
        last_step = (step == last_idx);
`endif
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and status outputs; abort beats both start and step completion
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (last_step) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath: latch operands on accept, iterate in RUN, publish hi/lo entering DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mreg     <= '0;
            acc      <= '0;
            step     <= '0;
            signed_q <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else if (accept) begin
            mcand_q  <= extend_operand(mcand, is_signed);
            mreg     <= {extend_operand(mplier, is_signed), 1'b0};
            acc      <= '0;
            step     <= '0;
            signed_q <= is_signed;
        end else if ((state == ST_RUN) && !abort) begin
            acc  <= acc_nxt;
            mreg <= mreg_nxt;
            step <= step + 5'd1;
            if (last_step) begin
                hi <= acc_nxt[63:32];
                lo <= acc_nxt[31:0];
            end
        end
    end

endmodule

// File: tb/tb_booth_mult_ctrl.sv
// Self-checking bench for booth_mult_ctrl; results are checked against
// plain 64-bit arithmetic. Honours BOOTH_EARLY_TERM_EN for latency checks.
module tb_booth_mult_ctrl;

    localparam int MAXLAT = 40;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        is_signed;
    logic        abort;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_fail   = 0;

    booth_mult_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_signed (is_signed),
        .abort     (abort),
        .mcand     (mcand),
        .mplier    (mplier),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Reference product from ordinary integer arithmetic
    function automatic logic [63:0] ref_product(input logic [31:0] a,
                                                input logic [31:0] b,
                                                input logic        s);
        longint sa;
        longint sb;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        return {32'h0, a} * {32'h0, b};
    endfunction

    function automatic int fixed_latency(input logic s);
        return s ? 17 : 18;
    endfunction

    // Issue one operation; lat counts cycles from the accept cycle to the done cycle
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output int lat, output logic got);
        @(negedge clk);
        start = 1'b1; is_signed = s; mcand = a; mplier = b;
        @(negedge clk);
        start = 1'b0; mcand = $urandom; mplier = $urandom; is_signed = 1'($urandom_range(0, 1));
        lat = 1;
        while (done !== 1'b1 && lat < MAXLAT) begin
            @(negedge clk);
            lat++;
        end
        got = (done === 1'b1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; is_signed = 1'b0;
        mcand = '0; mplier = '0;
        #23;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done got %b want 0", done); end
        n_checks++; if (hi !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_hi got %h want 0", hi); end
        n_checks++; if (lo !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_lo got %h want 0", lo); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("[TB] FAIL post_reset_idle got busy=%b done=%b want 0/0", busy, done); end
    endtask

    task automatic check_op(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic s, input logic [63:0] want);
        int   lat;
        logic got;
        do_op(a, b, s, lat, got);
        n_checks++; if (!got) begin n_fail++; $display("[TB] FAIL %s_timeout no done within %0d cycles", name, MAXLAT); end
        n_checks++; if ({hi, lo} !== want) begin n_fail++; $display("[TB] FAIL %s_result got %h want %h", name, {hi, lo}, want); end
`ifdef BOOTH_EARLY_TERM_EN
        n_checks++; if (lat > fixed_latency(s) || lat < 2) begin n_fail++; $display("[TB] FAIL %s_latency got %0d want 2..%0d", name, lat, fixed_latency(s)); end
`else
        n_checks++; if (lat != fixed_latency(s)) begin n_fail++; $display("[TB] FAIL %s_latency got %0d want %0d", name, lat, fixed_latency(s)); end
`endif
    endtask

    task automatic test_directed();
        check_op("s7xm3", 32'd7, 32'hFFFF_FFFD, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB);
        check_op("uffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
        check_op("s8x8", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
        check_op("u8x8", 32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000);
        check_op("s1xm1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001);
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            b = $urandom;
            s = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0: b = 32'h0;
                1: b = 32'hFFFF_FFFF;
                2: a = 32'h8000_0000;
                3: b = 32'(b >> $urandom_range(0, 31));
                default: ;
            endcase
            check_op("random", a, b, s, ref_product(a, b, s));
        end
    endtask

    task automatic test_abort();
        logic [63:0] prior;
        int          lat;
        logic        got;
        do_op(32'd1234, 32'd5678, 1'b0, lat, got);
        prior = {hi, lo};
        n_checks++; if (prior !== 64'd7006652) begin n_fail++; $display("[TB] FAIL abort_prior got %h want %h", prior, 64'd7006652); end
        @(negedge clk);
        start = 1'b1; is_signed = 1'b1; mcand = 32'h1357_9BDF; mplier = 32'h6DB6_DB6D;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c < 5; c++) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_idle got busy=%b done=%b want 0/0", busy, done); end
        n_checks++; if ({hi, lo} !== prior) begin n_fail++; $display("[TB] FAIL abort_hold got %h want %h", {hi, lo}, prior); end
        check_op("after_abort", 32'hFFFF_FF00, 32'h0000_0123, 1'b1, ref_product(32'hFFFF_FF00, 32'h0000_0123, 1'b1));
        // abort together with start in IDLE must block the request
        @(negedge clk);
        start = 1'b1; abort = 1'b1; mcand = 32'd3; mplier = 32'd3;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_start_idle got busy=%b want 0", busy); end
        // abort during DONE has no effect on the result just published
        do_op(32'd99, 32'd101, 1'b0, lat, got);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_checks++; if ({hi, lo} !== 64'd9999) begin n_fail++; $display("[TB] FAIL abort_in_done got %h want %h", {hi, lo}, 64'd9999); end
    endtask

    task automatic test_start_during_run();
        int          dones = 0;
        logic [63:0] cap   = '0;
        @(negedge clk);
        start = 1'b1; is_signed = 1'b1; mcand = 32'hDEAD_BEEF; mplier = 32'h6DB6_DB6D;
        @(negedge clk);
        start = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL run_busy got %b want 1", busy); end
        for (int c = 1; c <= MAXLAT; c++) begin
            if (done === 1'b1) begin
                dones++;
                cap = {hi, lo};
            end
            if (c == 3) begin
                start = 1'b1; mcand = 32'd11; mplier = 32'd13; is_signed = 1'b0;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        n_checks++; if (dones != 1) begin n_fail++; $display("[TB] FAIL ignore_start_dones got %0d want 1", dones); end
        n_checks++; if (cap !== ref_product(32'hDEAD_BEEF, 32'h6DB6_DB6D, 1'b1)) begin
            n_fail++; $display("[TB] FAIL ignore_start_result got %h want %h", cap, ref_product(32'hDEAD_BEEF, 32'h6DB6_DB6D, 1'b1));
        end
    endtask

    task automatic test_back_to_back();
        check_op("b2b_first", 32'h0001_0001, 32'hFFFF_0000, 1'b0, ref_product(32'h0001_0001, 32'hFFFF_0000, 1'b0));
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_done_high got %b want 1", done); end
        check_op("b2b_second", 32'h8765_4321, 32'h7654_3210, 1'b1, ref_product(32'h8765_4321, 32'h7654_3210, 1'b1));
        @(negedge clk);
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL done_pulse_width got %b want 0", done); end
    endtask

    task automatic test_early_term();
`ifdef BOOTH_EARLY_TERM_EN
        int   lat;
        logic got;
        do_op(32'd5, 32'd1, 1'b1, lat, got);
        n_checks++; if (!got || lat > 3) begin n_fail++; $display("[TB] FAIL early_5x1_latency got %0d want <=3", lat); end
        n_checks++; if ({hi, lo} !== 64'd5) begin n_fail++; $display("[TB] FAIL early_5x1_result got %h want 5", {hi, lo}); end
`endif
        check_op("mplier_zero", 32'hABCD_0123, 32'h0, 1'b1, 64'h0);
        check_op("s5x1", 32'd5, 32'd1, 1'b1, 64'd5);
    endtask

    task automatic test_reset_mid_run();
        int dones = 0;
        @(negedge clk);
        start = 1'b1; is_signed = 1'b1; mcand = 32'h1234_5678; mplier = 32'h5A5A_5A5A;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c < 6; c++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            n_fail++; $display("[TB] FAIL reset_mid_run got busy=%b done=%b hi=%h lo=%h want all 0", busy, done, hi, lo);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        n_checks++; if (dones != 0 || {hi, lo} !== 64'h0) begin
            n_fail++; $display("[TB] FAIL reset_discard got dones=%0d hilo=%h want 0/0", dones, {hi, lo});
        end
        check_op("after_reset", 32'h1234_5678, 32'h5A5A_5A5A, 1'b1, ref_product(32'h1234_5678, 32'h5A5A_5A5A, 1'b1));
    endtask

    // Run every scenario in order, then report
    initial begin
        test_reset();
        test_directed();
        test_random();
        test_abort();
        test_start_during_run();
        test_back_to_back();
        test_early_term();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
